stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 16, data word width in bits.
REQ-002 The module SHALL expose parameter DEPTH, default 16, number of entries (power of two, >= 2).
REQ-003 Reset rst SHALL be asynchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 push  input  1  push request from control unit (EXECUTE state).
REQ-007 pop  input  1  pop request from control unit (EXECUTE state).
REQ-008 din  input  WIDTH  data to push (datapath result bus).
REQ-009 clr_err  input  1  synchronous clear of sticky error flags.
REQ-010 dout  output  WIDTH  current top-of-stack, combinational.
REQ-011 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 unf  output  1  sticky underflow flag.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH register array; entry i is written only by the push paths below; array contents are not reset.
REQ-017 dout SHALL equal mem[count-1] when count > 0 and all-zero when empty, in the same cycle, so pop and register write-back complete in one EXECUTE cycle.
REQ-018 Push only, not full: mem[count] <= din, count <= count+1 at the clock edge; dout = din from the next cycle.
REQ-019 Push only, full: no write, count unchanged, ovf <= 1.
REQ-020 Pop only, not empty: count <= count-1; popped word is the dout value presented during the pop cycle.
REQ-021 Pop only, empty: count stays 0, ovf unchanged, unf <= 1, dout stays 0.
REQ-022 Push and pop, not empty (including full): mem[count-1] <= din, count unchanged, no error flag set (replace-top).
REQ-023 Push and pop, empty: handled as push only (mem[0] <= din, count <= 1); unf not set.
REQ-024 Neither asserted: no state change.
REQ-025 clr_err SHALL clear ovf and unf at the next edge; an error event in the same cycle takes priority and sets its flag.
REQ-026 empty and full SHALL be decoded combinationally from count; count never exceeds DEPTH nor wraps below 0.
REQ-027 All state updates SHALL occur only on the rising edge of clk, except reset.

Reset
REQ-028 Asserting rst at any time, including mid-push or mid-pop, SHALL immediately force count = 0, ovf = 0, unf = 0; hence empty = 1, full = 0, dout = 0.
REQ-029 The first edge after rst deasserts SHALL process push/pop normally; a push/pop sampled while rst is high SHALL be discarded.

Verification
REQ-030 Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> count 3, dout 0x3333; three pops -> dout reads 0x3333, 0x2222, 0x1111 in the pop cycles, then empty = 1, dout = 0.
REQ-031 Push 16 words 0x0000..0x000F -> full = 1, count 16; 17th push 0xBEEF -> count 16, dout 0x000F, ovf = 1.
REQ-032 From empty, pop -> unf = 1, count 0; then clr_err -> unf = 0; clr_err together with another empty pop -> unf remains 1.
REQ-033 With stack holding 0xAAAA, 0xBBBB, push+pop with din 0xCCCC -> count 2, dout 0xCCCC; pop -> dout 0xAAAA; push+pop from empty with din 0x5555 -> count 1, dout 0x5555, unf = 0.
REQ-034 Full stack, push+pop with din 0x7777 -> count 16, dout 0x7777, ovf = 0.
REQ-035 Push 5 words, assert rst asynchronously mid-cycle together with push -> count 0, empty = 1, dout 0, flags 0 immediately and after release.

Source files
------------

// File: rtl/stack_if.sv
// Bundle between the control unit (master) and the LIFO stack (slave).
//
// push/pop are level requests sampled on every rising clk edge; there is no
// ready back-pressure. A request always completes in the cycle it is
// presented. Overflow and underflow are reported through the sticky ovf/unf
// flags, and the request is otherwise ignored. dout, count, empty and full
// reflect the current registered stack state combinationally.
interface stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, din, clr_err,
        input  dout, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din, clr_err,
        output dout, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/stack_unit.sv
// LIFO operand stack: DEPTH x WIDTH register storage with a combinational
// top-of-stack read, so a pop and its register write-back fit in one cycle.
// A push and a pop together replace the top entry. Error flags are sticky.
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input logic     clk,
    input logic     rst,
    stack_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          is_empty;
    logic          is_full;
    logic [AW-1:0] top_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = AW'(count_q - CW'(1));

    // Next-state decode for count, sticky flags and the single storage write port.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q & ~bus.clr_err;
        unf_d   = unf_q & ~bus.clr_err;
        wr_en   = 1'b0;
        wr_addr = top_idx;
        if (bus.push && bus.pop && !is_empty) begin
            // Replace-top: count is unchanged and no error can occur.
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (bus.push) begin
            // Also covers push+pop on an empty stack.
            if (!is_full) begin
                wr_en   = 1'b1;
                wr_addr = count_q[AW-1:0];
                count_d = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (bus.pop) begin
            if (!is_empty) begin
                count_d = count_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // Storage array: not reset, because entries above count are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.din;
        end
    end

    // Occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.dout  = is_empty ? '0 : mem_q[top_idx];
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios plus a randomized run against a
// queue-based LIFO reference model.
module tb_stack_unit;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the back of the queue is the top of stack.
    logic [WIDTH-1:0] model_q [$];
    logic             model_ovf;
    logic             model_unf;

    logic             drv_push;
    logic             drv_pop;
    logic [WIDTH-1:0] drv_din;
    logic             drv_clr;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [WIDTH-1:0] exp_top();
        if (model_q.size() == 0) return '0;
        return model_q[model_q.size() - 1];
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endfunction

    function automatic void model_step();
        bit ev_ovf = 0;
        bit ev_unf = 0;
        if (drv_push && drv_pop && model_q.size() > 0) begin
            model_q[model_q.size() - 1] = drv_din;
        end else if (drv_push) begin
            if (model_q.size() < DEPTH) model_q.push_back(drv_din);
            else ev_ovf = 1;
        end else if (drv_pop) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
            else ev_unf = 1;
        end
        if (drv_clr) begin
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end
        if (ev_ovf) model_ovf = 1'b1;
        if (ev_unf) model_unf = 1'b1;
    endfunction

    // Driver: present one cycle's request.
    task automatic drive(input logic p, input logic o, input logic [WIDTH-1:0] d, input logic c);
        drv_push = p; drv_pop = o; drv_din = d; drv_clr = c;
        bus.push = p; bus.pop = o; bus.din = d; bus.clr_err = c;
    endtask

    // Advance through one rising edge, update the model, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'hDEAD, 1'b0);
        @(posedge clk);
        #1;
        model_reset();
        n_checks++; if (bus.count !== '0)   begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++; if (bus.dout !== '0)    begin n_fail++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
        n_checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", bus.ovf, bus.unf); end
        drive(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_lifo();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, vals[i], 1'b0);
            tick();
        end
        n_checks++; if (bus.count !== CW'(3))  begin n_fail++; $display("FAIL lifo_count: got %0d want 3", bus.count); end
        n_checks++; if (bus.dout !== 16'h3333) begin n_fail++; $display("FAIL lifo_top: got %h want 3333", bus.dout); end
        for (int i = 2; i >= 0; i--) begin
            drive(1'b0, 1'b1, '0, 1'b0);
            n_checks++; if (bus.dout !== vals[i]) begin n_fail++; $display("FAIL lifo_pop%0d: got %h want %h", i, bus.dout, vals[i]); end
            tick();
        end
        n_checks++; if (bus.empty !== 1'b1 || bus.dout !== '0) begin n_fail++; $display("FAIL lifo_empty: got empty=%b dout=%h want 1 0000", bus.empty, bus.dout); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, WIDTH'(i), 1'b0);
            tick();
        end
        n_checks++; if (bus.full !== 1'b1 || bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_fill: got full=%b count=%0d want 1 %0d", bus.full, bus.count, DEPTH); end
        drive(1'b1, 1'b0, 16'hBEEF, 1'b0);
        tick();
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", bus.count, DEPTH); end
        n_checks++; if (bus.dout !== 16'h000F)    begin n_fail++; $display("FAIL ovf_dout: got %h want 000f", bus.dout); end
        n_checks++; if (bus.ovf !== 1'b1)         begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, '0, 1'b0);
            tick();
        end
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        n_checks++; if (bus.ovf !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_clear: got ovf=%b empty=%b want 0 1", bus.ovf, bus.empty); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, '0, 1'b0);
        tick();
        n_checks++; if (bus.unf !== 1'b1 || bus.count !== '0) begin n_fail++; $display("FAIL unf_set: got unf=%b count=%0d want 1 0", bus.unf, bus.count); end
        n_checks++; if (bus.ovf !== 1'b0 || bus.dout !== '0)  begin n_fail++; $display("FAIL unf_side: got ovf=%b dout=%h want 0 0000", bus.ovf, bus.dout); end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        n_checks++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", bus.unf); end
        drive(1'b0, 1'b1, '0, 1'b1);
        tick();
        n_checks++; if (bus.unf !== 1'b1) begin n_fail++; $display("FAIL unf_priority: got %b want 1", bus.unf); end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_replace();
        drive(1'b1, 1'b0, 16'hAAAA, 1'b0); tick();
        drive(1'b1, 1'b0, 16'hBBBB, 1'b0); tick();
        drive(1'b1, 1'b1, 16'hCCCC, 1'b0); tick();
        n_checks++; if (bus.count !== CW'(2) || bus.dout !== 16'hCCCC) begin n_fail++; $display("FAIL repl_top: got count=%0d dout=%h want 2 cccc", bus.count, bus.dout); end
        drive(1'b0, 1'b1, '0, 1'b0); tick();
        n_checks++; if (bus.dout !== 16'hAAAA) begin n_fail++; $display("FAIL repl_pop: got %h want aaaa", bus.dout); end
        drive(1'b0, 1'b1, '0, 1'b0); tick();
        drive(1'b1, 1'b1, 16'h5555, 1'b0); tick();
        n_checks++; if (bus.count !== CW'(1) || bus.dout !== 16'h5555 || bus.unf !== 1'b0) begin n_fail++; $display("FAIL repl_empty: got count=%0d dout=%h unf=%b want 1 5555 0", bus.count, bus.dout, bus.unf); end
        drive(1'b0, 1'b1, '0, 1'b0); tick();
    endtask

    task automatic test_full_replace();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 16'h7777, 1'b0);
        tick();
        n_checks++; if (bus.count !== CW'(DEPTH) || bus.dout !== 16'h7777 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL full_repl: got count=%0d dout=%h ovf=%b want %0d 7777 0", bus.count, bus.dout, bus.ovf, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, '0, 1'b0);
            n_checks++; if (bus.dout !== exp_top()) begin n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, bus.dout, exp_top()); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, '0, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 16'hABCD, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL arst_now: got count=%0d empty=%b full=%b want 0 1 0", bus.count, bus.empty, bus.full); end
        n_checks++; if (bus.dout !== '0 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin n_fail++; $display("FAIL arst_now_out: got dout=%h ovf=%b unf=%b want 0000 0 0", bus.dout, bus.ovf, bus.unf); end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.dout !== '0 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin n_fail++; $display("FAIL arst_after: got count=%0d empty=%b dout=%h ovf=%b unf=%b want 0 1 0000 0 0", bus.count, bus.empty, bus.dout, bus.ovf, bus.unf); end
    endtask

    task automatic test_random();
        int push_bias;
        for (int i = 0; i < 600; i++) begin
            push_bias = ((i / 60) % 2 == 0) ? 8 : 3;
            drive(($urandom_range(0, 9) < push_bias), ($urandom_range(0, 9) < 5),
                  WIDTH'($urandom), ($urandom_range(0, 19) == 0));
            n_checks++; if (bus.dout !== exp_top()) begin n_fail++; $display("FAIL rand_dout[%0d]: got %h want %h", i, bus.dout, exp_top()); end
            tick();
            n_checks++; if (bus.count !== CW'(model_q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, bus.count, model_q.size()); end
            n_checks++; if (bus.empty !== (model_q.size() == 0) || bus.full !== (model_q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_status[%0d]: got empty=%b full=%b size %0d", i, bus.empty, bus.full, model_q.size()); end
            n_checks++; if (bus.ovf !== model_ovf || bus.unf !== model_unf) begin n_fail++; $display("FAIL rand_flags[%0d]: got ovf=%b unf=%b want %b %b", i, bus.ovf, bus.unf, model_ovf, model_unf); end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        model_reset();
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_full_replace();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
